cache_controller: RTL

- Sequences the direct-mapped, write-through data cache between the CPU memory stage and a multi-cycle main memory.
- Runs an invalidate sweep of every cache line after reset.
- Serves read hits in zero wait cycles; stalls the CPU on read misses (fetch, then fill) and on all writes (write-through, cache updated on hit).
- Keeps saturating hit and miss counters for performance tests.

---
 rtl/cache_pkg.sv | 28 ++
 rtl/cache_sweep.sv | 32 +++
 rtl/cache_controller.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the write-through data cache controller.
package cache_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    INIT      = 3'd0,
    IDLE      = 3'd1,
    MEM_READ  = 3'd2,
    FILL      = 3'd3,
    MEM_WRITE = 3'd4
  } cache_state_t;

  // Default geometry: 4096 one-word lines of 32 bits.
  localparam int unsigned CACHE_INDEX_BITS = 12;
  localparam int unsigned CACHE_WORD_SIZE  = 32;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cache_sweep.sv
// Line-invalidate sweep counter: walks every index once after reset.
module cache_sweep
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = CACHE_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  i_en,
  output logic [INDEX_BITS-1:0] o_index,
  output logic                  o_done
);

  logic [INDEX_BITS-1:0] r_index;

  // Advance one line per enabled cycle; wraps to 0 after the last line,
  // so a later sweep restarts cleanly.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_index <= {INDEX_BITS{1'b0}};
    end else if (i_en) begin
      r_index <= r_index + {{(INDEX_BITS-1){1'b0}}, 1'b1};
    end else begin
      r_index <= r_index;
    end
  end

  assign o_index = r_index;
  // High while the final line is being invalidated.
  assign o_done  = (r_index == {INDEX_BITS{1'b1}});

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-through data cache controller: sequences CPU loads
// and stores against the cache array and a multi-cycle main memory.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS     = CACHE_INDEX_BITS,
  parameter int unsigned WORD_SIZE      = CACHE_WORD_SIZE,
  // Value the hit counter takes on reset; zero in normal use.
  parameter logic [31:0] HIT_COUNT_INIT = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [WORD_SIZE-1:0]  cpu_addr,
  input  logic [WORD_SIZE-1:0]  cpu_wdata,
  output logic [WORD_SIZE-1:0]  cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  cache_hit,
  input  logic [WORD_SIZE-1:0]  cache_rdata,
  output logic [WORD_SIZE-1:0]  cache_addr,
  output logic                  cache_we,
  output logic [WORD_SIZE-1:0]  cache_wdata,
  output logic                  cache_inv,
  output logic [INDEX_BITS-1:0] cache_inv_index,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_SIZE-1:0]  mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  input  logic                  mem_ack,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  cache_state_t r_state;
  cache_state_t w_next_state;

  logic [WORD_SIZE-1:0] r_mem_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic                 r_hit;
  logic [WORD_SIZE-1:0] r_latch;
  logic [31:0]          r_hit_count;
  logic [31:0]          r_miss_count;

  logic                  w_capture;
  logic                  w_latch_en;
  logic                  w_hit_inc;
  logic                  w_miss_inc;
  logic                  w_sweep_en;
  logic                  w_sweep_done;
  logic [INDEX_BITS-1:0] w_sweep_index;

  cache_sweep #(
    .INDEX_BITS (INDEX_BITS)
  ) u_sweep (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_en    (w_sweep_en),
    .o_index (w_sweep_index),
    .o_done  (w_sweep_done)
  );

  // State, captured request, fill latch and performance counters.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state      <= INIT;
      r_mem_addr   <= {WORD_SIZE{1'b0}};
      r_wdata      <= {WORD_SIZE{1'b0}};
      r_hit        <= 1'b0;
      r_latch      <= {WORD_SIZE{1'b0}};
      r_hit_count  <= HIT_COUNT_INIT;
      r_miss_count <= 32'h0000_0000;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_mem_addr <= cpu_addr;
        r_wdata    <= cpu_wdata;
        r_hit      <= cache_hit;
      end
      if (w_latch_en) begin
        r_latch <= mem_rdata;
      end
      if (w_hit_inc) begin
        r_hit_count <= sat_inc(r_hit_count);
      end
      if (w_miss_inc) begin
        r_miss_count <= sat_inc(r_miss_count);
      end
    end
  end

  // Next-state and per-state output decode.
  always_comb begin
    w_next_state = r_state;
    cpu_ready    = 1'b0;
    cpu_rdata    = r_latch;
    cache_we     = 1'b0;
    cache_wdata  = r_latch;
    cache_inv    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    w_capture    = 1'b0;
    w_latch_en   = 1'b0;
    w_hit_inc    = 1'b0;
    w_miss_inc   = 1'b0;
    w_sweep_en   = 1'b0;

    case (r_state)
      INIT: begin
        cache_inv  = 1'b1;
        w_sweep_en = 1'b1;
        if (w_sweep_done) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = INIT;
        end
      end

      IDLE: begin
        cpu_rdata = cache_rdata;
        if (cpu_req && cpu_we) begin
          // Stores always go to memory; the hit flag decides later
          // whether the cached copy is updated too.
          w_capture    = 1'b1;
          w_next_state = MEM_WRITE;
        end else if (cpu_req && cache_hit) begin
          cpu_ready = 1'b1;
          w_hit_inc = 1'b1;
        end else if (cpu_req) begin
          w_capture    = 1'b1;
          w_miss_inc   = 1'b1;
          w_next_state = MEM_READ;
        end else begin
          w_next_state = IDLE;
        end
      end

      MEM_READ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_latch_en   = 1'b1;
          w_next_state = FILL;
        end else begin
          w_next_state = MEM_READ;
        end
      end

      FILL: begin
        cache_we     = 1'b1;
        cache_wdata  = r_latch;
        cpu_ready    = 1'b1;
        cpu_rdata    = r_latch;
        w_next_state = IDLE;
      end

      MEM_WRITE: begin
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        cache_wdata = r_wdata;
        if (mem_ack) begin
          cpu_ready    = 1'b1;
          cache_we     = r_hit;
          w_next_state = IDLE;
        end else begin
          w_next_state = MEM_WRITE;
        end
      end

      default: begin
        w_next_state = INIT;
      end
    endcase
  end

  assign cache_addr      = cpu_addr;
  assign cache_inv_index = w_sweep_index;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_wdata;
  assign hit_count       = r_hit_count;
  assign miss_count      = r_miss_count;

endmodule
